// File: rtl/id_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl_pkg
// Shared definitions for the decode-stage hazard scheduler.
//   - Default bus widths for register address, data and stall counter.
//   - Forwarding-source encoding driven to decode on fwd_sel_rj/fwd_sel_rkd.
// ---------------------------------------------------------------------------
package id_hazard_ctrl_pkg;

    // Default bus widths
    localparam int REG_AW_DEF = 5;
    localparam int DW_DEF     = 32;
    localparam int CNT_W_DEF  = 32;

    // Forwarding source select, ordered so that a larger code means an
    // older producer (EXE is youngest, WB is oldest).
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,   // register-file read data
        FWD_ES = 2'd1,   // EXE result
        FWD_MS = 2'd2,   // MEM result (includes load data)
        FWD_WS = 2'd3    // WB result
    } fwd_sel_e;

endpackage : id_hazard_ctrl_pkg

// File: rtl/id_hazard_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
// Combinational forwarding selector for one decode source operand.
// Compares the source address against the EXE/MEM/WB shadow slots, picks the
// youngest matching producer and muxes the corresponding value.
//
// Ports
//   i_src       source register address
//   i_used      source is actually read by the instruction
//   i_es_slot   EXE slot  {v, we, dest}
//   i_ms_slot   MEM slot  {v, we, dest}
//   i_ws_slot   WB  slot  {v, we, dest}
//   i_rf_data   register-file read data
//   i_es_data   EXE result
//   i_ms_data   MEM result
//   i_ws_data   WB result
//   o_sel       forwarding source (fwd_sel_e encoding)
//   o_value     forwarded operand value
//   o_es_hit    the selected producer is the EXE slot
// ---------------------------------------------------------------------------
module hazard_fwd_sel
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_used,
    input  logic [REG_AW+1:0] i_es_slot,
    input  logic [REG_AW+1:0] i_ms_slot,
    input  logic [REG_AW+1:0] i_ws_slot,
    input  logic [DW-1:0]     i_rf_data,
    input  logic [DW-1:0]     i_es_data,
    input  logic [DW-1:0]     i_ms_data,
    input  logic [DW-1:0]     i_ws_data,
    output logic [1:0]        o_sel,
    output logic [DW-1:0]     o_value,
    output logic              o_es_hit
);

    // A slot is a producer for this source when it is valid, writes the
    // register file, targets this address, and the source is a real read
    // of a register other than r0.
    function automatic logic slot_match(
        input logic [REG_AW+1:0] slot,
        input logic [REG_AW-1:0] src,
        input logic              used
    );
        return slot[REG_AW+1] & slot[REG_AW] &
               (slot[REG_AW-1:0] == src) & (src != '0) & used;
    endfunction

    logic     w_es_match;
    logic     w_ms_match;
    logic     w_ws_match;
    fwd_sel_e w_sel;

    assign w_es_match = slot_match(i_es_slot, i_src, i_used);
    assign w_ms_match = slot_match(i_ms_slot, i_src, i_used);
    assign w_ws_match = slot_match(i_ws_slot, i_src, i_used);

    // Youngest producer wins: EXE over MEM over WB.
    always_comb begin
        // NOTE: default first so every path assigns w_sel and no latch is inferred.
        w_sel = FWD_RF;
        if (w_es_match) begin
            w_sel = FWD_ES;
        end else if (w_ms_match) begin
            w_sel = FWD_MS;
        end else if (w_ws_match) begin
            w_sel = FWD_WS;
        end
    end

    // Single 4:1 mux per operand keeps the decode branch-compare path short.
    always_comb begin
        o_value = i_rf_data;
        unique case (w_sel)
            FWD_RF: o_value = i_rf_data;
            FWD_ES: o_value = i_es_data;
            FWD_MS: o_value = i_ms_data;
            FWD_WS: o_value = i_ws_data;
        endcase
    end

    assign o_sel    = w_sel;
    // EXE has top priority, so an EXE match is always the selected producer.
    assign o_es_hit = w_es_match;

endmodule : hazard_fwd_sel

// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
// Register-hazard scheduler beside the decode stage. Tracks the destination,
// write enable and load flag of the instructions in EXE, MEM and WB, and from
// that drives operand forwarding, a load-use stall and a stall-cycle counter.
// Decode gates its ds_ready_go with ~ds_stall.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   ds_valid                     decode holds an instruction
//   ds_rj / ds_rj_used           source 1 address / is read
//   ds_rkd / ds_rkd_used         source 2 address / is read
//   ds_dest/ds_gr_we/ds_load_op  decode instruction's write target info
//   ds_fire, es_fire,
//   ms_fire, ws_fire             stage transfer strobes
//   es_result/ms_result/
//   ws_result                    current stage results
//   rf_rdata1, rf_rdata2         register-file read data
//   rj_value, rkd_value          forwarded operand values
//   fwd_sel_rj, fwd_sel_rkd      forwarding source per operand
//   ds_stall                     load-use interlock
//   stall_cnt                    stalled decode cycles (wraps)
// ---------------------------------------------------------------------------
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ds_valid,
    input  logic [REG_AW-1:0] ds_rj,
    input  logic              ds_rj_used,
    input  logic [REG_AW-1:0] ds_rkd,
    input  logic              ds_rkd_used,
    input  logic [REG_AW-1:0] ds_dest,
    input  logic              ds_gr_we,
    input  logic              ds_load_op,
    input  logic              ds_fire,
    input  logic              es_fire,
    input  logic              ms_fire,
    input  logic              ws_fire,
    input  logic [DW-1:0]     es_result,
    input  logic [DW-1:0]     ms_result,
    input  logic [DW-1:0]     ws_result,
    input  logic [DW-1:0]     rf_rdata1,
    input  logic [DW-1:0]     rf_rdata2,
    output logic [DW-1:0]     rj_value,
    output logic [DW-1:0]     rkd_value,
    output logic [1:0]        fwd_sel_rj,
    output logic [1:0]        fwd_sel_rkd,
    output logic              ds_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Shadow slots
    logic              r_es_v, r_es_we, r_es_load;
    logic [REG_AW-1:0] r_es_dest;
    logic              r_ms_v, r_ms_we, r_ms_load;
    logic [REG_AW-1:0] r_ms_dest;
    logic              r_ws_v, r_ws_we, r_ws_load;
    logic [REG_AW-1:0] r_ws_dest;

    logic [CNT_W-1:0]  r_stall_cnt;

    logic [REG_AW+1:0] w_es_slot, w_ms_slot, w_ws_slot;
    logic              w_rj_es_hit, w_rkd_es_hit;
    logic              w_ds_stall;
    // The load flag only gates the interlock while in EXE; past WB it is
    // carried for scoreboard completeness and has no consumer.
    logic              w_unused_ws_load;

    assign w_unused_ws_load = r_ws_load;

    // Valid bits and counter: reset discards every pending slot. A load into
    // a slot takes priority over clearing it, so a stage can receive and
    // pass on an instruction on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: non-blocking assignments so all slots see pre-edge values and shift together.
            r_es_v      <= 1'b0;
            r_ms_v      <= 1'b0;
            r_ws_v      <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (ds_fire) begin
                r_es_v <= 1'b1;
            end else if (es_fire) begin
                r_es_v <= 1'b0;
            end

            if (es_fire) begin
                r_ms_v <= r_es_v;
            end else if (ms_fire) begin
                r_ms_v <= 1'b0;
            end

            if (ms_fire) begin
                r_ws_v <= r_ms_v;
            end else if (ws_fire) begin
                r_ws_v <= 1'b0;
            end

            if (w_ds_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: slot payload is not reset; it is qualified by the valid bit everywhere it is used.
    always_ff @(posedge clk) begin
        if (ds_fire) begin
            r_es_dest <= ds_dest;
            r_es_we   <= ds_gr_we;
            r_es_load <= ds_load_op;
        end
        if (es_fire) begin
            r_ms_dest <= r_es_dest;
            r_ms_we   <= r_es_we;
            r_ms_load <= r_es_load;
        end
        if (ms_fire) begin
            r_ws_dest <= r_ms_dest;
            r_ws_we   <= r_ms_we;
            r_ws_load <= r_ms_load;
        end
    end

    assign w_es_slot = {r_es_v, r_es_we, r_es_dest};
    assign w_ms_slot = {r_ms_v, r_ms_we, r_ms_dest};
    assign w_ws_slot = {r_ws_v, r_ws_we, r_ws_dest};

    hazard_fwd_sel #(
        .REG_AW (REG_AW),
        .DW     (DW)
    ) u_fwd_rj (
        .i_src     (ds_rj),
        .i_used    (ds_rj_used),
        .i_es_slot (w_es_slot),
        .i_ms_slot (w_ms_slot),
        .i_ws_slot (w_ws_slot),
        .i_rf_data (rf_rdata1),
        .i_es_data (es_result),
        .i_ms_data (ms_result),
        .i_ws_data (ws_result),
        .o_sel     (fwd_sel_rj),
        .o_value   (rj_value),
        .o_es_hit  (w_rj_es_hit)
    );

    hazard_fwd_sel #(
        .REG_AW (REG_AW),
        .DW     (DW)
    ) u_fwd_rkd (
        .i_src     (ds_rkd),
        .i_used    (ds_rkd_used),
        .i_es_slot (w_es_slot),
        .i_ms_slot (w_ms_slot),
        .i_ws_slot (w_ws_slot),
        .i_rf_data (rf_rdata2),
        .i_es_data (es_result),
        .i_ms_data (ms_result),
        .i_ws_data (ws_result),
        .o_sel     (fwd_sel_rkd),
        .o_value   (rkd_value),
        .o_es_hit  (w_rkd_es_hit)
    );

    // Load data is not available until MEM, so a consumer of a load still in
    // EXE waits one cycle and then picks the value up from the MEM forward.
    assign w_ds_stall = ds_valid & (w_rj_es_hit | w_rkd_es_hit) & r_es_load;

    assign ds_stall  = w_ds_stall;
    assign stall_cnt = r_stall_cnt;

endmodule : id_hazard_ctrl

// File: tb/tb_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_ctrl
// Self-checking bench for id_hazard_ctrl: a vector table of single-producer
// scenarios, hand-written multi-cycle sequences, and randomized traffic
// against an in-flight instruction model.
// ---------------------------------------------------------------------------
module tb_id_hazard_ctrl;
    import id_hazard_ctrl_pkg::*;

    localparam int REG_AW = 5;
    localparam int DW     = 32;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              resetn;
    logic              ds_valid;
    logic [REG_AW-1:0] ds_rj, ds_rkd, ds_dest;
    logic              ds_rj_used, ds_rkd_used, ds_gr_we, ds_load_op;
    logic              ds_fire, es_fire, ms_fire, ws_fire;
    logic [DW-1:0]     es_result, ms_result, ws_result, rf_rdata1, rf_rdata2;
    logic [DW-1:0]     rj_value, rkd_value;
    logic [1:0]        fwd_sel_rj, fwd_sel_rkd;
    logic              ds_stall;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_hazard_ctrl #(.REG_AW(REG_AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ds_valid    (ds_valid),
        .ds_rj       (ds_rj),
        .ds_rj_used  (ds_rj_used),
        .ds_rkd      (ds_rkd),
        .ds_rkd_used (ds_rkd_used),
        .ds_dest     (ds_dest),
        .ds_gr_we    (ds_gr_we),
        .ds_load_op  (ds_load_op),
        .ds_fire     (ds_fire),
        .es_fire     (es_fire),
        .ms_fire     (ms_fire),
        .ws_fire     (ws_fire),
        .es_result   (es_result),
        .ms_result   (ms_result),
        .ws_result   (ws_result),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rj_value    (rj_value),
        .rkd_value   (rkd_value),
        .fwd_sel_rj  (fwd_sel_rj),
        .fwd_sel_rkd (fwd_sel_rkd),
        .ds_stall    (ds_stall),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode must never transfer while the interlock is raised.
    always @(negedge clk) begin
        if (resetn && ds_fire) check("fire_while_stalled", ds_stall, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ds_valid = 0; ds_rj = '0; ds_rj_used = 0; ds_rkd = '0; ds_rkd_used = 0;
        ds_dest = '0; ds_gr_we = 0; ds_load_op = 0;
        ds_fire = 0; es_fire = 0; ms_fire = 0; ws_fire = 0;
        es_result = 32'hE5E5_0001; ms_result = 32'h4D4D_0002; ws_result = 32'hB0B0_0003;
        rf_rdata1 = 32'hAAAA_0001; rf_rdata2 = 32'h5555_0002;
    endtask

    task automatic do_reset();
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    task automatic push(input logic [4:0] dest, input logic we, input logic ld);
        ds_dest = dest; ds_gr_we = we; ds_load_op = ld; ds_fire = 1;
        tick();
        ds_fire = 0;
    endtask

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] rf);
        case (sel)
            2'd1:    return es_result;
            2'd2:    return ms_result;
            2'd3:    return ws_result;
            default: return rf;
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] p_dest; logic p_we; logic p_load; int adv;
        logic valid;
        logic [4:0] rj;  logic rj_used;
        logic [4:0] rkd; logic rkd_used;
        logic [1:0] exp_rj; logic [1:0] exp_rkd; logic exp_stall;
    } vec_t;

    vec_t vecs[10];

    // ---------------- random reference model ----------------
    // Each in-flight instruction is what the spec says the pipeline holds;
    // index 0 is the youngest (EXE), index 2 the oldest (WB).
    typedef struct packed { logic v; logic [4:0] dest; logic we; logic load; } minst_t;
    minst_t     m_pipe[3];
    logic [31:0] m_cnt;

    function automatic int youngest_writer(input logic [4:0] r, input logic used);
        if (!used || r == 0) return -1;
        for (int s = 0; s < 3; s++)
            if (m_pipe[s].v && m_pipe[s].we && m_pipe[s].dest == r) return s;
        return -1;
    endfunction

    initial begin
        clear_inputs();
        resetn = 0;
        tick(); tick();
        resetn = 1;

        // Reset state with a decode instruction that would otherwise look up r5
        ds_valid = 1; ds_rj = 5; ds_rj_used = 1; ds_rkd = 7; ds_rkd_used = 1;
        settle();
        check("reset_sel_rj", fwd_sel_rj, FWD_RF);
        check("reset_sel_rkd", fwd_sel_rkd, FWD_RF);
        check("reset_rj_value", rj_value, 32'hAAAA_0001);
        check("reset_rkd_value", rkd_value, 32'h5555_0002);
        check("reset_stall", ds_stall, 0);
        check("reset_cnt", stall_cnt, 0);
        tick();

        // ---- table-driven single producer cases ----
        //        dest we ld adv val rj u  rkd u  erj erkd estall
        vecs[0] = '{5,  1, 0, 0, 1,  5, 1, 6, 1, 1, 0, 0};
        vecs[1] = '{5,  1, 1, 0, 1,  6, 1, 5, 1, 0, 1, 1};
        vecs[2] = '{5,  1, 1, 0, 1,  5, 1, 5, 0, 1, 0, 1};
        vecs[3] = '{5,  1, 1, 0, 1,  4, 1, 5, 0, 0, 0, 0};
        vecs[4] = '{0,  1, 1, 0, 1,  0, 1, 0, 1, 0, 0, 0};
        vecs[5] = '{5,  0, 1, 0, 1,  5, 1, 5, 1, 0, 0, 0};
        vecs[6] = '{5,  1, 1, 1, 1,  5, 1, 5, 1, 2, 2, 0};
        vecs[7] = '{31, 1, 0, 2, 1, 31, 1, 1, 1, 3, 0, 0};
        vecs[8] = '{31, 1, 1, 2, 1,  2, 1,31, 1, 0, 3, 0};
        vecs[9] = '{5,  1, 1, 0, 0,  5, 1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            do_reset();
            push(vecs[i].p_dest, vecs[i].p_we, vecs[i].p_load);
            if (vecs[i].adv >= 1) begin es_fire = 1; tick(); es_fire = 0; end
            if (vecs[i].adv >= 2) begin ms_fire = 1; tick(); ms_fire = 0; end
            ds_valid = vecs[i].valid;
            ds_rj = vecs[i].rj;   ds_rj_used = vecs[i].rj_used;
            ds_rkd = vecs[i].rkd; ds_rkd_used = vecs[i].rkd_used;
            settle();
            check($sformatf("vec%0d_sel_rj", i), fwd_sel_rj, vecs[i].exp_rj);
            check($sformatf("vec%0d_sel_rkd", i), fwd_sel_rkd, vecs[i].exp_rkd);
            check($sformatf("vec%0d_rj_value", i), rj_value, pick(vecs[i].exp_rj, rf_rdata1));
            check($sformatf("vec%0d_rkd_value", i), rkd_value, pick(vecs[i].exp_rkd, rf_rdata2));
            check($sformatf("vec%0d_stall", i), ds_stall, vecs[i].exp_stall);
            tick();
        end

        // ---- RAW from EXE: add r5, then add r6 = r5 + r0 ----
        clear_inputs(); do_reset();
        push(5, 1, 0);
        es_result = 32'h1234;
        ds_valid = 1; ds_rj = 5; ds_rj_used = 1; ds_rkd = 0; ds_rkd_used = 1;
        settle();
        check("raw_sel_rj", fwd_sel_rj, FWD_ES);
        check("raw_rj_value", rj_value, 32'h1234);
        check("raw_sel_rkd", fwd_sel_rkd, FWD_RF);
        check("raw_stall", ds_stall, 0);
        tick();

        // ---- Load-use: ld.w r7, then beq r7, r8 ----
        clear_inputs(); do_reset();
        push(7, 1, 1);
        ds_valid = 1; ds_rj = 7; ds_rj_used = 1; ds_rkd = 8; ds_rkd_used = 1;
        es_fire = 1;  // EXE drains while decode waits
        settle();
        check("lu_stall_bubble", ds_stall, 1);
        check("lu_cnt_before", stall_cnt, 0);
        tick();
        es_fire = 0; ms_result = 32'hDEADBEEF;
        settle();
        check("lu_stall_released", ds_stall, 0);
        check("lu_cnt_after", stall_cnt, 1);
        check("lu_sel_rj", fwd_sel_rj, FWD_MS);
        check("lu_rj_value", rj_value, 32'hDEADBEEF);
        tick();

        // ---- Backpressure: load stuck in EXE for 5 cycles ----
        clear_inputs(); do_reset();
        push(9, 1, 1);
        ds_valid = 1; ds_rj = 9; ds_rj_used = 1;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("bp_stall_c%0d", c), ds_stall, 1);
            check($sformatf("bp_sel_c%0d", c), fwd_sel_rj, FWD_ES);
            tick();
        end
        settle();
        check("bp_cnt_5", stall_cnt, 5);
        check("bp_slot_held", fwd_sel_rj, FWD_ES);
        es_fire = 1;
        tick();
        es_fire = 0;
        settle();
        check("bp_release_stall", ds_stall, 0);
        check("bp_release_sel", fwd_sel_rj, FWD_MS);
        check("bp_cnt_6", stall_cnt, 6);
        tick();

        // ---- Priority: r3 in EXE, MEM and WB ----
        clear_inputs(); do_reset();
        ds_dest = 3; ds_gr_we = 1; ds_load_op = 0; ds_fire = 1;
        tick();
        es_fire = 1;
        tick();
        ms_fire = 1;
        tick();
        ds_fire = 0; es_fire = 0; ms_fire = 0;
        ds_valid = 1; ds_rj = 3; ds_rj_used = 1;
        settle();
        check("prio_es", fwd_sel_rj, FWD_ES);
        check("prio_es_value", rj_value, es_result);
        es_fire = 1; ms_fire = 1; ws_fire = 1;
        tick();
        es_fire = 0; ms_fire = 0; ws_fire = 0;
        settle();
        check("prio_ms", fwd_sel_rj, FWD_MS);
        check("prio_ms_value", rj_value, ms_result);
        ms_fire = 1;
        tick();
        ms_fire = 0;
        settle();
        check("prio_ws", fwd_sel_rj, FWD_WS);
        check("prio_ws_value", rj_value, ws_result);
        ws_fire = 1;
        tick();
        ws_fire = 0;
        settle();
        check("prio_drained", fwd_sel_rj, FWD_RF);
        tick();

        // ---- Reset mid-stream with all slots valid and a stall pending ----
        clear_inputs(); do_reset();
        ds_dest = 3; ds_gr_we = 1; ds_load_op = 1; ds_fire = 1;
        tick();
        es_fire = 1;
        tick();
        ms_fire = 1;
        tick();
        ds_fire = 0; es_fire = 0; ms_fire = 0;
        ds_valid = 1; ds_rj = 3; ds_rj_used = 1; ds_rkd = 3; ds_rkd_used = 1;
        tick();
        settle();
        check("rst_pre_stall", ds_stall, 1);
        check("rst_pre_cnt", stall_cnt, 1);
        resetn = 0;
        tick();
        resetn = 1;
        settle();
        check("rst_sel_rj", fwd_sel_rj, FWD_RF);
        check("rst_sel_rkd", fwd_sel_rkd, FWD_RF);
        check("rst_stall", ds_stall, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_rj_value", rj_value, rf_rdata1);
        tick();

        // ---- Randomized traffic against the in-flight model ----
        clear_inputs(); do_reset();
        for (int s = 0; s < 3; s++) m_pipe[s] = '0;
        m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int   wj, wk;
            logic m_stall;
            logic [1:0] e_sj, e_sk;
            minst_t nxt[3];
            resetn      = ($urandom_range(0, 99) != 0);
            ds_valid    = ($urandom_range(0, 3) != 0);
            ds_rj       = 5'($urandom_range(0, 7));
            ds_rkd      = 5'($urandom_range(0, 7));
            ds_rj_used  = ($urandom_range(0, 4) != 0);
            ds_rkd_used = ($urandom_range(0, 4) != 0);
            ds_dest     = 5'($urandom_range(0, 7));
            ds_gr_we    = ($urandom_range(0, 3) != 0);
            ds_load_op  = ($urandom_range(0, 2) == 0);
            es_fire     = 1'($urandom_range(0, 1));
            ms_fire     = 1'($urandom_range(0, 1));
            ws_fire     = 1'($urandom_range(0, 1));
            es_result = $urandom; ms_result = $urandom; ws_result = $urandom;
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;

            wj = youngest_writer(ds_rj, ds_rj_used);
            wk = youngest_writer(ds_rkd, ds_rkd_used);
            e_sj = (wj < 0) ? 2'd0 : 2'(wj + 1);
            e_sk = (wk < 0) ? 2'd0 : 2'(wk + 1);
            m_stall = ds_valid && (wj == 0 || wk == 0) && m_pipe[0].load;
            ds_fire = ds_valid && !m_stall && ($urandom_range(0, 1) == 1);

            settle();
            check("rnd_sel_rj", fwd_sel_rj, e_sj);
            check("rnd_sel_rkd", fwd_sel_rkd, e_sk);
            check("rnd_rj_value", rj_value, pick(e_sj, rf_rdata1));
            check("rnd_rkd_value", rkd_value, pick(e_sk, rf_rdata2));
            check("rnd_stall", ds_stall, m_stall);
            check("rnd_cnt", stall_cnt, m_cnt);

            if (!resetn) begin
                for (int s = 0; s < 3; s++) m_pipe[s] = '0;
                m_cnt = 0;
            end else begin
                nxt[0] = ds_fire ? minst_t'{1'b1, ds_dest, ds_gr_we, ds_load_op}
                       : es_fire ? '0 : m_pipe[0];
                nxt[1] = es_fire ? m_pipe[0] : ms_fire ? '0 : m_pipe[1];
                nxt[2] = ms_fire ? m_pipe[1] : ws_fire ? '0 : m_pipe[2];
                for (int s = 0; s < 3; s++) m_pipe[s] = nxt[s];
                if (m_stall) m_cnt = m_cnt + 1;
            end
            tick();
        end

        resetn = 1;
        clear_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_id_hazard_ctrl
